alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_arbiter.sv
// Round-robin arbiter feeding a single-slot ALU: one requester is granted per cycle
// and its result is held in an output register until the consumer takes it.
module alu_arbiter #(
    parameter int N = 4,
    parameter int W = 64
) (
    input  logic           c,
    input  logic           rst,
    input  logic [N-1:0]   req_valid,
    output logic [N-1:0]   req_ready,
    input  logic [4*N-1:0] req_op,
    input  logic [W*N-1:0] req_a,
    input  logic [W*N-1:0] req_b,
    output logic           rsp_valid,
    output logic [1:0]     rsp_id,
    output logic [W-1:0]   rsp_data,
    input  logic           rsp_ready,
    output logic           busy
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

    localparam logic [W-1:0] ONE = W'(1);

    state_t       state;
    state_t       state_nxt;
    logic [1:0]   ptr;
    logic [1:0]   ptr_nxt;
    logic [1:0]   win;
    logic         found;
    logic         slot_free;
    logic         drain;
    logic         grant;
    logic [3:0]   op_sel;
    logic [W-1:0] a_sel;
    logic [W-1:0] b_sel;
    logic [W-1:0] alu_res;

    assign drain     = rsp_valid && rsp_ready;
    assign slot_free = !rsp_valid || rsp_ready;
    assign grant     = slot_free && found && !rst;

    // Search starts at ptr and wraps, so the last winner becomes lowest priority.
    always_comb begin
        int idx;
        idx   = 0;
        found = 1'b0;
        win   = 2'd0;
        for (int k = 0; k < N; k++) begin
            idx = (int'(ptr) + k) % N;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                win   = 2'(idx);
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (grant) begin
            for (int i = 0; i < N; i++) begin
                if (int'(win) == i) begin
                    req_ready[i] = 1'b1;
                end
            end
        end
    end

    always_comb begin
        op_sel = '0;
        a_sel  = '0;
        b_sel  = '0;
        for (int i = 0; i < N; i++) begin
            if (int'(win) == i) begin
                op_sel = req_op[4*i +: 4];
                a_sel  = req_a[W*i +: W];
                b_sel  = req_b[W*i +: W];
            end
        end
    end

    // Division by zero yields all ones for div and the dividend for mod.
    always_comb begin
        alu_res = '0;
        case (op_sel)
            4'd0:  alu_res = a_sel + b_sel;
            4'd1:  alu_res = a_sel - b_sel;
            4'd2:  alu_res = a_sel * b_sel;
            4'd3:  alu_res = (b_sel == '0) ? '1 : (a_sel / b_sel);
            4'd4:  alu_res = (b_sel == '0) ? a_sel : (a_sel % b_sel);
            4'd5:  alu_res = {{(W-1){1'b0}}, ((|a_sel) && (|b_sel))};
            4'd6:  alu_res = {{(W-1){1'b0}}, ((|a_sel) || (|b_sel))};
            4'd7:  alu_res = {{(W-1){1'b0}}, ~(|a_sel)};
            4'd8:  alu_res = ~a_sel;
            4'd9:  alu_res = a_sel & b_sel;
            4'd10: alu_res = a_sel | b_sel;
            4'd11: alu_res = a_sel ^ b_sel;
            4'd12: alu_res = a_sel << b_sel[5:0];
            4'd13: alu_res = a_sel >> b_sel[5:0];
            4'd14: alu_res = a_sel + ONE;
            4'd15: alu_res = a_sel - ONE;
        endcase
    end

    always_comb begin
        ptr_nxt = ptr;
        if (grant) begin
            ptr_nxt = (int'(win) == N - 1) ? 2'd0 : (win + 2'd1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY: if (grant) state_nxt = FULL;
            FULL:  if (drain && !grant) state_nxt = EMPTY;
        endcase
    end

    always_ff @(posedge c or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            ptr      <= 2'd0;
            rsp_id   <= 2'd0;
            rsp_data <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            if (grant) begin
                rsp_id   <= win;
                rsp_data <= alu_res;
            end
        end
    end

    assign rsp_valid = (state == FULL);
    assign busy      = rsp_valid;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed and random stimulus for alu_arbiter, checked against a reference ALU,
// a round-robin pointer model and a result scoreboard.
module tb_alu_arbiter;

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
    } exp_t;

    logic         c;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [15:0]  req_op;
    logic [255:0] req_a;
    logic [255:0] req_b;
    logic         rsp_valid;
    logic [1:0]   rsp_id;
    logic [63:0]  rsp_data;
    logic         rsp_ready;
    logic         busy;

    logic [3:0]   op_t [4];
    logic [63:0]  a_t [4];
    logic [63:0]  b_t [4];

    exp_t sb[$];
    int   ptr_m;
    int   total;
    int   bad;

    logic [3:0] order_exp [5];
    int         id_exp [5];

    alu_arbiter #(.N(4), .W(64)) dut (
        .c(c),
        .rst(rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op(req_op),
        .req_a(req_a),
        .req_b(req_b),
        .rsp_valid(rsp_valid),
        .rsp_id(rsp_id),
        .rsp_data(rsp_data),
        .rsp_ready(rsp_ready),
        .busy(busy)
    );

    initial c = 1'b0;
    always #5 c = ~c;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_op[4*i +: 4] = op_t[i];
            req_a[64*i +: 64] = a_t[i];
            req_b[64*i +: 64] = b_t[i];
        end
    end

    function automatic logic [63:0] ref_alu(logic [3:0] op, logic [63:0] a, logic [63:0] b);
        case (op)
            4'd0:  return a + b;
            4'd1:  return a - b;
            4'd2:  return a * b;
            4'd3:  return (b == 64'd0) ? 64'hFFFF_FFFF_FFFF_FFFF : a / b;
            4'd4:  return (b == 64'd0) ? a : a % b;
            4'd5:  return (a != 64'd0 && b != 64'd0) ? 64'd1 : 64'd0;
            4'd6:  return (a != 64'd0 || b != 64'd0) ? 64'd1 : 64'd0;
            4'd7:  return (a == 64'd0) ? 64'd1 : 64'd0;
            4'd8:  return ~a;
            4'd9:  return a & b;
            4'd10: return a | b;
            4'd11: return a ^ b;
            4'd12: return a << b[5:0];
            4'd13: return a >> b[5:0];
            4'd14: return a + 64'd1;
            4'd15: return a - 64'd1;
            default: return 64'd0;
        endcase
    endfunction

    task automatic check_output(string tag, logic [63:0] observed, logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Called just after a falling edge with inputs set; checks, clocks, updates the model.
    task automatic apply_stimulus();
        logic [3:0] exp_ready;
        int         win;
        exp_t       e;
        #1;
        exp_ready = 4'b0000;
        win = -1;
        if (sb.size() == 0 || rsp_ready) begin
            for (int k = 0; k < 4; k++) begin
                if (win < 0 && req_valid[(ptr_m + k) % 4]) win = (ptr_m + k) % 4;
            end
        end
        if (win >= 0) exp_ready[win] = 1'b1;
        check_output("req_ready", 64'(req_ready), 64'(exp_ready));
        check_output("rsp_valid", 64'(rsp_valid), 64'(sb.size() != 0));
        check_output("busy", 64'(busy), 64'(sb.size() != 0));
        if (sb.size() != 0) begin
            check_output("rsp_id", 64'(rsp_id), 64'(sb[0].id));
            check_output("rsp_data", rsp_data, sb[0].data);
        end
        @(posedge c);
        if (sb.size() != 0 && rsp_ready) void'(sb.pop_front());
        if (win >= 0) begin
            e.id = 2'(win);
            e.data = ref_alu(op_t[win], a_t[win], b_t[win]);
            sb.push_back(e);
            ptr_m = (win + 1) % 4;
        end
        @(negedge c);
    endtask

    task automatic set_req(int i, logic [3:0] op, logic [63:0] a, logic [63:0] b);
        op_t[i] = op;
        a_t[i] = a;
        b_t[i] = b;
    endtask

    initial begin
        total = 0;
        bad = 0;
        ptr_m = 0;
        order_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        id_exp = '{0, 1, 2, 3, 0};
        for (int i = 0; i < 4; i++) set_req(i, 4'd0, 64'(i + 1), 64'(10 * (i + 1)));

        // Reset state, with requests already pending.
        rst = 1'b1;
        rsp_ready = 1'b1;
        req_valid = 4'b1111;
        #3;
        check_output("reset_rsp_valid", 64'(rsp_valid), 64'd0);
        check_output("reset_busy", 64'(busy), 64'd0);
        check_output("reset_rsp_id", 64'(rsp_id), 64'd0);
        check_output("reset_rsp_data", rsp_data, 64'd0);
        check_output("reset_req_ready", 64'(req_ready), 64'd0);
        @(posedge c);
        @(negedge c);
        check_output("reset_hold_req_ready", 64'(req_ready), 64'd0);
        rst = 1'b0;

        // All four requesting from reset: grants rotate 0,1,2,3,0.
        for (int j = 0; j < 5; j++) begin
            #1;
            check_output("grant_order", 64'(req_ready), 64'(order_exp[j]));
            apply_stimulus();
            check_output("grant_order_id", 64'(rsp_id), 64'(id_exp[j]));
        end

        // Requester 1 adds 5 + 7.
        req_valid = 4'b0010;
        set_req(1, 4'd0, 64'd5, 64'd7);
        apply_stimulus();
        check_output("add_valid", 64'(rsp_valid), 64'd1);
        check_output("add_id", 64'(rsp_id), 64'd1);
        check_output("add_data", rsp_data, 64'd12);

        // Division by zero, shift and decrement corners.
        req_valid = 4'b0001;
        set_req(0, 4'd3, 64'd100, 64'd0);
        apply_stimulus();
        check_output("div_by_zero", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        set_req(0, 4'd4, 64'd100, 64'd0);
        apply_stimulus();
        check_output("mod_by_zero", rsp_data, 64'd100);
        set_req(0, 4'd13, 64'h80, 64'h44);
        apply_stimulus();
        check_output("shift_right", rsp_data, 64'h08);
        set_req(0, 4'd15, 64'd0, 64'd0);
        apply_stimulus();
        check_output("dec_wrap", rsp_data, 64'hFFFF_FFFF_FFFF_FFFF);
        req_valid = 4'b0000;
        apply_stimulus();
        check_output("drain_empty", 64'(rsp_valid), 64'd0);

        // Back-pressure: result held for 3 cycles while requester 2 waits.
        req_valid = 4'b0001;
        rsp_ready = 1'b0;
        set_req(0, 4'd2, 64'd6, 64'd7);
        apply_stimulus();
        req_valid = 4'b0100;
        set_req(2, 4'd1, 64'd10, 64'd3);
        for (int j = 0; j < 3; j++) begin
            #1;
            check_output("stall_req_ready", 64'(req_ready), 64'd0);
            check_output("stall_rsp_data", rsp_data, 64'd42);
            apply_stimulus();
        end
        rsp_ready = 1'b1;
        #1;
        check_output("release_grant", 64'(req_ready), 64'b0100);
        apply_stimulus();
        check_output("release_id", 64'(rsp_id), 64'd2);
        check_output("release_data", rsp_data, 64'd7);

        // Random traffic against the model.
        for (int j = 0; j < 40; j++) begin
            req_valid = 4'($urandom_range(0, 15));
            rsp_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < 4; i++) begin
                op_t[i] = 4'($urandom_range(0, 15));
                a_t[i] = {$urandom, $urandom};
                b_t[i] = ($urandom_range(0, 3) == 0) ? 64'd0 : {$urandom, $urandom};
            end
            apply_stimulus();
        end
        req_valid = 4'b0000;
        rsp_ready = 1'b1;
        apply_stimulus();
        apply_stimulus();

        // Asynchronous reset while FULL, with ptr left at 3 beforehand.
        req_valid = 4'b0100;
        rsp_ready = 1'b0;
        set_req(2, 4'd0, 64'd1, 64'd2);
        apply_stimulus();
        #2;
        rst = 1'b1;
        #1;
        check_output("async_rst_valid", 64'(rsp_valid), 64'd0);
        check_output("async_rst_busy", 64'(busy), 64'd0);
        check_output("async_rst_data", rsp_data, 64'd0);
        check_output("async_rst_req_ready", 64'(req_ready), 64'd0);
        sb.delete();
        ptr_m = 0;
        req_valid = 4'b1010;
        rsp_ready = 1'b1;
        set_req(1, 4'd9, 64'hF0F0, 64'h0FF0);
        set_req(3, 4'd0, 64'd3, 64'd4);
        @(negedge c);
        rst = 1'b0;
        #1;
        check_output("post_rst_grant", 64'(req_ready), 64'b0010);
        apply_stimulus();
        check_output("post_rst_id", 64'(rsp_id), 64'd1);
        check_output("post_rst_data", rsp_data, 64'h00F0);
        req_valid = 4'b0000;
        apply_stimulus();
        apply_stimulus();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
